dcache_responder: RTL

Data-cache-side responder for the LSU memory request interface. It accepts `dc_req_t` requests from the LSU and services one request at a time over a simple 64-bit memory port. It returns `dc_resp_t` responses, or a `nack_t` when a new request cannot be taken. It sits between the LSU and the memory/L2 bus, standing in for a blocking L1 data cache.

---
 rtl/dcache_responder_pkg.sv | 70 +++++++
 rtl/dcache_lane_align.sv | 48 ++++
 rtl/dcache_responder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/dcache_responder_pkg.sv
// Shared types for the blocking data-cache responder and its lane aligner.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package dcache_responder_pkg;

  localparam int MEM_BYTES = 8;
  localparam int XLEN      = 64;
  localparam int BR_W      = 12;
  localparam int LDQ_IDX_W = 4;
  localparam int STQ_IDX_W = 5;
  localparam int LSU_IDX_W = 5;

  typedef enum logic [1:0] {
    DCR_IDLE = 2'd0,
    DCR_REQ  = 2'd1,
    DCR_WAIT = 2'd2,
    DCR_RESP = 2'd3
  } dcr_state_t;

  // bits[2] set means the load is zero-extended (unsigned funct3)
  typedef struct packed {
    logic                 load;
    logic [1:0]           mem_size;
    logic [2:0]           bits;
    logic [BR_W-1:0]      br_mask;
    logic [LDQ_IDX_W-1:0] ldq_idx;
    logic [STQ_IDX_W-1:0] stq_idx;
  } uop_t;

  typedef struct packed {
    logic            dreq_valid;
    uop_t            uop;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic            is_hella;
  } dc_req_t;

  typedef struct packed {
    logic            dresp_valid;
    uop_t            uop;
    logic [XLEN-1:0] data;
    logic            is_hella;
  } dc_resp_t;

  typedef struct packed {
    logic                 valid;
    logic                 cache_nack;
    logic                 isload;
    logic [LSU_IDX_W-1:0] lsu_idx;
  } nack_t;

  typedef struct packed {
    logic [BR_W-1:0] resolve_mask;
    logic [BR_W-1:0] mispredict_mask;
    logic            mispredict;
  } brupdate_t;

  // True when the byte offset is a multiple of the access size
  function automatic logic addr_aligned(input logic [2:0] off, input logic [1:0] size);
    logic ok;
    case (size)
      2'd0:    ok = 1'b1;
      2'd1:    ok = (off[0] == 1'b0);
      2'd2:    ok = (off[1:0] == 2'b00);
      default: ok = (off == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dcache_lane_align.sv
// Byte-lane alignment: store strobe/data shift and load extract/extend.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module dcache_lane_align
  import dcache_responder_pkg::*;
(
  input  logic [1:0]           i_size,
  input  logic [2:0]           i_off,
  input  logic                 i_unsigned,
  input  logic [XLEN-1:0]      i_wdata,
  input  logic [XLEN-1:0]      i_rdata,
  output logic [MEM_BYTES-1:0] o_wstrb,
  output logic [XLEN-1:0]      o_wdata,
  output logic [XLEN-1:0]      o_rdata
);

  logic [5:0]           w_shamt;
  logic [MEM_BYTES-1:0] w_base_strb;
  logic [XLEN-1:0]      w_shifted;

  assign w_shamt   = {i_off, 3'b000};
  assign o_wstrb   = w_base_strb << i_off;
  assign o_wdata   = i_wdata << w_shamt;
  assign w_shifted = i_rdata >> w_shamt;

  // Strobe pattern for the access size before lane shifting
  always_comb begin
    w_base_strb = 8'h01;
    case (i_size)
      2'd0:    w_base_strb = 8'h01;
      2'd1:    w_base_strb = 8'h03;
      2'd2:    w_base_strb = 8'h0F;
      default: w_base_strb = 8'hFF;
    endcase
  end

  // Truncate load data to the access size, then sign- or zero-extend
  always_comb begin
    o_rdata = w_shifted;
    case (i_size)
      2'd0:    o_rdata = {{56{~i_unsigned & w_shifted[7]}},  w_shifted[7:0]};
      2'd1:    o_rdata = {{48{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      2'd2:    o_rdata = {{32{~i_unsigned & w_shifted[31]}}, w_shifted[31:0]};
      default: o_rdata = w_shifted;
    endcase
  end

endmodule

// File: rtl/dcache_responder.sv
// Blocking L1D stand-in: one LSU request at a time over a 64-bit memory port.
// Latency: request in cycle N -> mem_req_valid_o at N+1, response at N+4 with zero-wait memory.
// Backpressure: requests arriving while busy are nacked the same cycle; memory stalls via ready/resp.
module dcache_responder
  import dcache_responder_pkg::*;
#(
  parameter int PADDR_W        = 56,
  parameter bit ACCEPT_ON_RESP = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  dc_req_t              req_i,
  input  brupdate_t            brupdate_i,
  input  logic                 flush_i,
  output dc_resp_t             resp_o,
  output nack_t                nack_o,
  output logic                 busy_o,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [PADDR_W-1:0]   mem_addr_o,
  output logic                 mem_we_o,
  output logic [XLEN-1:0]      mem_wdata_o,
  output logic [MEM_BYTES-1:0] mem_wstrb_o,
  input  logic                 mem_resp_valid_i,
  input  logic [XLEN-1:0]      mem_rdata_i
);

  dcr_state_t           r_state;
  dcr_state_t           w_state_nxt;
  uop_t                 r_uop;
  logic [PADDR_W-1:0]   r_addr;
  logic [XLEN-1:0]      r_data;
  logic                 r_is_hella;
  logic                 r_killed;
  logic [XLEN-1:0]      r_rdata;
  dc_resp_t             r_resp;

  uop_t                 w_uop_upd;
  uop_t                 w_req_uop_upd;
  logic                 w_kill_held;
  logic                 w_kill_in;
  logic                 w_can_accept;
  logic                 w_accept;
  logic                 w_in_req;
  logic [MEM_BYTES-1:0] w_wstrb;
  logic [XLEN-1:0]      w_wdata;
  logic [XLEN-1:0]      w_load_data;
  logic                 w_unused_addr_hi;

  assign w_unused_addr_hi = ^req_i.addr[XLEN-1:PADDR_W];

  // A response cycle may double as an accept cycle so back-to-back loads lose no slot
  assign w_can_accept = (r_state == DCR_IDLE) || (ACCEPT_ON_RESP && (r_state == DCR_RESP));
  assign w_accept     = req_i.dreq_valid && w_can_accept;

  // Stores are already committed, so only loads are killable
  assign w_kill_held = r_uop.load &&
                       (flush_i || (brupdate_i.mispredict && |(r_uop.br_mask & brupdate_i.mispredict_mask)));
  assign w_kill_in   = req_i.uop.load &&
                       (flush_i || (brupdate_i.mispredict && |(req_i.uop.br_mask & brupdate_i.mispredict_mask)));

  // Branch masks shed resolved branches every cycle, both held and incoming
  always_comb begin
    w_uop_upd             = r_uop;
    w_uop_upd.br_mask     = r_uop.br_mask & ~brupdate_i.resolve_mask;
    w_req_uop_upd         = req_i.uop;
    w_req_uop_upd.br_mask = req_i.uop.br_mask & ~brupdate_i.resolve_mask;
  end

  dcache_lane_align u_align (
    .i_size     (r_uop.mem_size),
    .i_off      (r_addr[2:0]),
    .i_unsigned (r_uop.bits[2]),
    .i_wdata    (r_data),
    .i_rdata    (r_rdata),
    .o_wstrb    (w_wstrb),
    .o_wdata    (w_wdata),
    .o_rdata    (w_load_data)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= DCR_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: a kill never changes the path, the memory handshake always completes
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DCR_IDLE: if (w_accept)         w_state_nxt = DCR_REQ;
      DCR_REQ:  if (mem_req_ready_i)  w_state_nxt = DCR_WAIT;
      DCR_WAIT: if (mem_resp_valid_i) w_state_nxt = DCR_RESP;
      DCR_RESP: w_state_nxt = w_accept ? DCR_REQ : DCR_IDLE;
      default:  w_state_nxt = DCR_IDLE;
    endcase
  end

  // Memory port: fields are zeroed outside REQ so the bus is quiet when idle
  always_comb begin
    w_in_req        = (r_state == DCR_REQ);
    mem_req_valid_o = w_in_req;
    mem_addr_o      = '0;
    mem_we_o        = 1'b0;
    mem_wdata_o     = '0;
    mem_wstrb_o     = '0;
    if (w_in_req) begin
      mem_addr_o = {r_addr[PADDR_W-1:3], 3'b000};
      mem_we_o   = ~r_uop.load;
      if (!r_uop.load) begin
        mem_wdata_o = w_wdata;
        mem_wstrb_o = w_wstrb;
      end
    end
  end

  // Reject any request the FSM cannot take this cycle
  always_comb begin
    nack_o = '0;
    if (req_i.dreq_valid && !w_accept) begin
      nack_o.valid      = 1'b1;
      nack_o.cache_nack = 1'b1;
      nack_o.isload     = req_i.uop.load;
      nack_o.lsu_idx    = req_i.uop.load ? LSU_IDX_W'(req_i.uop.ldq_idx) : req_i.uop.stq_idx;
    end
  end

  // Held transaction, kill tracking, read capture and the registered response pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_uop      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_is_hella <= 1'b0;
      r_killed   <= 1'b0;
      r_rdata    <= '0;
      r_resp     <= '0;
    end else begin
      r_resp <= '0;
      if ((r_state == DCR_RESP) && !r_killed && !w_kill_held) begin
        r_resp.dresp_valid <= 1'b1;
        r_resp.uop         <= w_uop_upd;
        r_resp.data        <= r_uop.load ? w_load_data : '0;
        r_resp.is_hella    <= r_is_hella;
      end
      if (w_accept) begin
        r_uop      <= w_req_uop_upd;
        r_addr     <= req_i.addr[PADDR_W-1:0];
        r_data     <= req_i.data;
        r_is_hella <= req_i.is_hella;
        r_killed   <= w_kill_in;
      end else if (r_state != DCR_IDLE) begin
        r_uop    <= w_uop_upd;
        r_killed <= r_killed | w_kill_held;
      end
      if ((r_state == DCR_WAIT) && mem_resp_valid_i) begin
        r_rdata <= mem_rdata_i;
      end
    end
  end

  assign resp_o = r_resp;
  assign busy_o = (r_state != DCR_IDLE);

  // The LSU only issues naturally aligned accesses; flag any that are not
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      assert (addr_aligned(req_i.addr[2:0], req_i.uop.mem_size));
    end
  end

endmodule
